// File: rtl/irq_pending_latch_pkg.sv
// irq_pkg: shared widths and FSM state type for the interrupt pending latch
package irq_pkg;
  localparam int N_LINES = 8;
  localparam int CODE_W  = 3;
  typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/priority_encoder8to3.sv
// priority_encoder8to3: combinational 8-to-3 encoder, highest set bit wins
// y: request vector, a: index of highest set bit (0 when none), valid: any bit set
module priority_encoder8to3
  import irq_pkg::*;
(
  input  logic [N_LINES-1:0] y,
  output logic [CODE_W-1:0]  a,
  output logic               valid
);
  always_comb begin
    a = '0;
    for (int i = 0; i < N_LINES; i++) if (y[i]) a = CODE_W'(i);
  end
  assign valid = |y;
endmodule

// File: rtl/irq_pending_latch.sv
// irq_pending_latch: synchronise requests, latch rising edges as pending, present highest-priority unmasked line with valid/ack
// clk/rst_n: clock and async active-low reset
// req: request lines (bit 7 highest), mask: 1 = selectable, ack: consumer accepts code
// clr_ovr: clears overrun, pend: pending vector, code/code_valid: presented index, overrun: sticky repeat-edge flags
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_LINES-1:0] req,
  input  logic [N_LINES-1:0] mask,
  input  logic               ack,
  input  logic               clr_ovr,
  output logic [N_LINES-1:0] pend,
  output logic [CODE_W-1:0]  code,
  output logic               code_valid,
  output logic [N_LINES-1:0] overrun
);
  logic [N_LINES-1:0] w_req_s;
  logic [N_LINES-1:0] r_req_q;
  logic [SYNC_STAGES:0] r_arm;
  logic               w_armed;
  logic [N_LINES-1:0] w_rise;
  logic [N_LINES-1:0] w_clr;
  logic [N_LINES-1:0] w_ovr_set;
  logic [CODE_W-1:0]  w_a;
  logic               w_valid;
  state_t             r_state;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_req_s = req;
  end else begin : g_sync
    for (genvar s = 0; s < SYNC_STAGES; s++) begin : g_st
      logic [N_LINES-1:0] w_d;
      logic [N_LINES-1:0] r_q;
      if (s == 0) begin : g_first
        assign w_d = req;
      end else begin : g_next
        assign w_d = g_st[s-1].r_q;
      end
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_q <= '0;
        else        r_q <= w_d;
    end
    assign w_req_s = g_st[SYNC_STAGES-1].r_q;
  end

  // Edges are suppressed until the synchroniser and req_q hold only post-reset samples,
  // so lines held high through reset never look like fresh rising edges.
  assign w_armed   = r_arm[SYNC_STAGES];
  assign w_rise    = w_req_s & ~r_req_q & {N_LINES{w_armed}};
  assign w_clr     = (code_valid & ack) ? (N_LINES'(1) << code) : '0;
  assign w_ovr_set = w_rise & pend & ~w_clr;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_req_q <= '0;
      r_arm   <= '0;
      pend    <= '0;
      overrun <= '0;
    end else begin
      r_req_q <= w_req_s;
      r_arm   <= (r_arm << 1) | (SYNC_STAGES+1)'(1);
      pend    <= (pend & ~w_clr) | w_rise;
      overrun <= (overrun & ~{N_LINES{clr_ovr}}) | w_ovr_set;
    end

  priority_encoder8to3 u_enc (
    .y     (pend & mask),
    .a     (w_a),
    .valid (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state    <= IDLE;
      code       <= '0;
      code_valid <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_valid) begin
        code       <= w_a;
        code_valid <= 1'b1;
        r_state    <= PRESENT;
      end
    end else if (ack) begin
      code_valid <= 1'b0;
      r_state    <= IDLE;
    end
endmodule

// File: tb/tb_irq_pending_latch.sv
// tb_irq_pending_latch: randomized and directed scoreboard bench against a cycle-level behavioural model
module tb_irq_pending_latch;
  localparam int S = 2;
  logic clk = 0, rst_n = 0;
  logic [7:0] req = 0, mask = 8'hFF;
  logic ack = 0, clr_ovr = 0;
  logic [7:0] pend, overrun;
  logic [2:0] code;
  logic code_valid;

  always #5 clk = ~clk;

  irq_pending_latch #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .ack(ack), .clr_ovr(clr_ovr),
    .pend(pend), .code(code), .code_valid(code_valid), .overrun(overrun)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic [7:0] ovr;
    logic       cv;
    logic [2:0] code;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  logic [7:0] hist[$];
  logic [7:0] m_pend, m_ovr;
  bit m_pres;
  int m_code;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_pend = 0;
    m_ovr  = 0;
    m_pres = 0;
    m_code = 0;
    sb.delete();
  endtask

  // An edge is a 0->1 step between two consecutive synchronised samples taken after reset;
  // the synchronised sample seen at an edge is the input sampled S edges earlier.
  task automatic model_step();
    logic [7:0] rise, clr, sel;
    exp_t e;
    rise = 0;
    hist.push_back(req);
    if (hist.size() > S + 2) void'(hist.pop_front());
    if (hist.size() == S + 2) rise = hist[1] & ~hist[0];
    clr = (m_pres && ack) ? 8'(1 << m_code) : 8'h00;
    sel = m_pend & mask;
    m_ovr  = (clr_ovr ? 8'h00 : m_ovr) | (rise & m_pend & ~clr);
    m_pend = (m_pend & ~clr) | rise;
    if (m_pres) begin
      if (ack) m_pres = 0;
    end else if (sel != 0) begin
      for (int i = 7; i >= 0; i--) if (sel[i]) begin m_code = i; break; end
      m_pres = 1;
    end
    e.pend = m_pend;
    e.ovr  = m_ovr;
    e.cv   = m_pres;
    e.code = 3'(m_code);
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("sb_pend", pend, e.pend);
      check("sb_overrun", overrun, e.ovr);
      check("sb_code_valid", code_valid, e.cv);
      if (e.cv) check("sb_code", code, e.code);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pend", pend, 0);
    check("rst_code", code, 0);
    check("rst_cv", code_valid, 0);
    check("rst_ovr", overrun, 0);
    #1 rst_n = 1;
    model_reset();
    tick(4);

    req = 8'h04;
    tick(3);
    check("t1_pend", pend, 8'h04);
    tick();
    check("t1_cv", code_valid, 1);
    check("t1_code", code, 2);
    ack = 1; tick(); ack = 0;
    check("t1_pend_clr", pend, 0);
    check("t1_cv_clr", code_valid, 0);
    req = 0; tick(3);

    req = 8'h01; tick(4);
    check("t2_code0", code, 0);
    req = 8'h81; tick(5);
    check("t2_frozen_cv", code_valid, 1);
    check("t2_frozen_code", code, 0);
    ack = 1; tick(); ack = 0;
    check("t2_gap", code_valid, 0);
    tick();
    check("t2_cv7", code_valid, 1);
    check("t2_code7", code, 7);
    ack = 1; tick(); ack = 0;
    req = 0; tick(4);

    req = 8'hFF; ack = 1;
    tick(24);
    ack = 0; req = 0;
    check("t3_pend", pend, 0);
    check("t3_cv", code_valid, 0);
    tick(4);

    mask = 8'h0F; req = 8'hF0; tick(6);
    check("t4_pend", pend, 8'hF0);
    check("t4_cv", code_valid, 0);
    mask = 8'hFF; tick();
    check("t4_code", code, 7);
    ack = 1; tick(8); ack = 0;
    req = 0; tick(4);

    mask = 8'h00;
    req = 8'h08; tick(2); req = 0; tick(2);
    req = 8'h08; tick(2); req = 0; tick(4);
    check("t5_ovr", overrun, 8'h08);
    clr_ovr = 1; tick(); clr_ovr = 0;
    check("t5_ovr_clr", overrun, 0);
    mask = 8'h08; tick(2);
    check("t5_code3", code, 3);
    req = 8'h08; tick(S);
    ack = 1; tick(); ack = 0; req = 0;
    check("t5_setwins_pend", pend & 8'h08, 8'h08);
    check("t5_setwins_ovr", overrun, 0);
    tick();
    ack = 1; tick(); ack = 0;
    tick(4);

    mask = 8'hFF; req = 8'h01; tick(5);
    check("t6_cv_pre", code_valid, 1);
    #2 rst_n = 0;
    #1;
    check("t6_pend", pend, 0);
    check("t6_code", code, 0);
    check("t6_cv", code_valid, 0);
    check("t6_ovr", overrun, 0);
    rst_n = 1;
    model_reset();
    tick(10);
    check("t6_nolatch_pend", pend, 0);
    check("t6_nolatch_cv", code_valid, 0);
    req = 0; tick(4);

    repeat (500) begin
      if ($urandom_range(0, 2) == 0) req = req ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      clr_ovr = ($urandom_range(0, 9) == 0);
      tick();
    end
    ack = 0; clr_ovr = 0;
    tick(2);
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/irq_pending_latch.md
# irq_pending_latch

Request-capture stage that sits directly upstream of `priority_encoder8to3`. It synchronises eight request lines, detects rising edges, and holds them in a pending register. The encoder selects the highest-priority unmasked pending line. That index is presented to the consumer with a valid/ack handshake, and the served pending bit is cleared on acceptance. Repeated edges on a line that is already pending are flagged as sticky overruns.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth on `req`; legal range 0..3, where 0 means `req` is already synchronous.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  8  request lines; bit 7 has the highest priority.
- `mask`  in  8  1 = line enabled for selection. Masked lines still latch as pending.
- `ack`  in  1  consumer accepts `code` in any cycle where `code_valid`=1.
- `clr_ovr`  in  1  single-cycle pulse; clears all `overrun` bits.
- `pend`  out  8  registered pending vector; feeds encoder input `y` and is exported for debug.
- `code`  out  3  index of the line being presented.
- `code_valid`  out  1  `code` is valid.
- `overrun`  out  8  sticky; set when an edge arrives on a line whose pending bit is already 1.

## Operation
- Edge detect: `rise = req_s & ~req_q`, where `req_s` is the synchronised `req` and `req_q` is `req_s` delayed one cycle. Only rising edges set pending bits; a held-high level does not re-set a bit.
- Pending update each edge: `pend <= (pend & ~clr_vec) | rise`.
  - `clr_vec` is one-hot at `code` when `code_valid & ack`; otherwise 0.
  - If the set and the clear hit the same bit in one cycle, the set wins. The bit stays 1 and no overrun is flagged for that bit.
- Overrun: `overrun[i]` is set when `rise[i]` and `pend[i]` are both 1 and bit i is not being cleared that cycle. It is cleared by `clr_ovr`. If `clr_ovr` and a new overrun coincide, the set wins.
- Selection: `sel = pend & mask` drives `priority_encoder8to3`, giving index `a` and flag `valid`. The highest set bit wins, so 8'hFF gives index 7.
- FSM with two states:
  - IDLE: `code_valid`=0. If the encoder `valid`=1, capture `a` into `code` and go to PRESENT.
  - PRESENT: `code_valid`=1 and `code` is frozen. Higher-priority arrivals and mask changes do not alter `code`.
  - PRESENT on `ack`=1: clear `pend[code]` and return to IDLE.
- `ack` while in IDLE is ignored and has no effect.
- Masking a line after it has been captured does not withdraw it; it is delivered.

## Timing
- Reset values: `pend`=0, `code`=0, `code_valid`=0, `overrun`=0, all synchroniser and `req_q` flops=0, FSM=IDLE.
- Reset release does not generate edges on lines that are already high. The first sample after reset loads `req_q` before `rise` is evaluated.
- `req` rising to `pend` bit set: `SYNC_STAGES`+1 edges.
- `pend` set to `code_valid`=1: +1 edge. Total with the default depth is 4 edges.
- Ack to next presentation: a `code_valid`&`ack` edge forces IDLE for at least 1 cycle. Back-to-back service yields at most one code every 2 cycles.
- `code` and `code_valid` are registered outputs. There is no combinational path from `req`, `mask` or `ack` to any output.
- Asserting `rst_n`=0 mid-handshake drops `code_valid` immediately (asynchronously) and loses all pending and overrun state.

## Structure
- Shared package `irq_pkg`:
  - `N_LINES`=8 and `CODE_W`=3.
  - FSM state enum `{IDLE, PRESENT}`.
- Sub-module: existing `priority_encoder8to3`, instantiated combinationally on `pend & mask`.
- The synchroniser is an inline generate loop, not a separate module.
- Target size is about 150 lines of RTL.

## Test plan
- Reset and single request: hold `rst_n`=0 with `req`=8'h00 and `mask`=8'hFF, then release. Raise `req`=8'h04. Expect `pend`=8'h04 after 3 edges, then `code_valid`=1 with `code`=2 on the next edge. Pulse `ack`, then expect `pend`=0 and `code_valid`=0.
- Priority with a frozen code: raise `req`=8'h01 and wait until `code`=0 is presented. Raise `req[7]` before acking. `code` must stay 0 until `ack`. Next expect `code`=7 after a 1-cycle IDLE gap.
- All lines: `req` goes 8'h00 to 8'hFF, with `ack` held high. Expect codes 7,6,5,4,3,2,1,0 in order, one every 2 cycles, then `pend`=0.
- Masking: with `mask`=8'h0F, raise `req`=8'hF0. Expect `pend`=8'hF0 and `code_valid` to stay 0. Set `mask`=8'hFF and expect `code`=7.
- Overrun and set-wins: pulse `req[3]` twice with `pend[3]` still pending and no ack. Expect `overrun`=8'h08. Pulse `clr_ovr` and expect `overrun`=0. Time a `req[3]` edge to land on the same edge as the `ack` clearing `pend[3]`. Expect `pend[3]` to stay 1 and no overrun.
- Mid-handshake reset: with `code_valid`=1, pulse `rst_n` low between clock edges. Expect every output at its reset value immediately. A `req` held high through the reset must not re-latch.
